lcd_write_scheduler: RTL
========================

LCD_WRITE_SCHEDULER -- requirements
Module: lcd_write_scheduler

Interface
- REQ-001: Parameter COLS, default 16: characters per display line; the legal range is 1..16.
- REQ-002: Parameter ACK_TIMEOUT, default 4: the maximum number of cycles to wait for lcd_busy to rise after a write strobe.
- REQ-003: clock  input  1  sole clock; all logic SHALL be clocked on its rising edge.
- REQ-004: reset  input  1  reset, synchronous and active-high.
- REQ-005: cmd_valid  input  1  the command requester has a byte pending (written with rs=0).
- REQ-006: cmd_data  input  8  the command byte.
- REQ-007: cmd_ready  output  1  the command byte is accepted on any cycle where cmd_valid and cmd_ready are both high.
- REQ-008: chr_valid  input  1  the character requester has a byte pending (written with rs=1).
- REQ-009: chr_data  input  8  the character byte.
- REQ-010: chr_ready  output  1  the character byte is accepted on any cycle where chr_valid and chr_ready are both high.
- REQ-011: lcd_busy  input  1  busy_flag from the lcd module.
- REQ-012: lcd_d  output  9  {rs, data[7:0]}, driven to the lcd module's d_in.
- REQ-013: lcd_data_ready  output  1  one-cycle write strobe to the lcd module's data_ready.
- REQ-014: cursor_pos  output  5  tracked cursor position: 0..COLS-1 on line 1, 16..16+COLS-1 on line 2.

Function
- REQ-015: The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and WRAP.
- REQ-016: In IDLE, cmd_ready SHALL equal !lcd_busy, and chr_ready SHALL equal !lcd_busy && !cmd_valid; in all other states, both ready outputs SHALL be 0.
- REQ-017: If cmd_valid and chr_valid are high in the same cycle, the command SHALL be accepted and the character SHALL wait.
- REQ-018: On acceptance in cycle N, lcd_d SHALL be set to {rs, byte} at N+1, lcd_data_ready SHALL be high only in cycle N+1, and the FSM SHALL enter WAIT_BUSY.
- REQ-019: lcd_d SHALL hold its value from the strobe cycle until the FSM leaves WAIT_DONE.
- REQ-020: WAIT_BUSY SHALL go to WAIT_DONE when lcd_busy is 1, and SHALL go to IDLE after ACK_TIMEOUT cycles with lcd_busy still 0.
- REQ-021: WAIT_DONE SHALL go to IDLE when lcd_busy is 0, or to WRAP if a wrap is pending (see REQ-027).
- REQ-022: After command 0x01 (clear) or 0x02 (home) is accepted, cursor_pos SHALL become 0.
- REQ-023: After a command with bit7 set is accepted, address 0x00..COLS-1 SHALL set cursor_pos to that address; 0x40..0x40+COLS-1 SHALL set it to 16 + (address - 0x40); any other address SHALL leave cursor_pos unchanged.
- REQ-024: All other commands SHALL leave cursor_pos unchanged.
- REQ-025: An accepted character SHALL increment cursor_pos.
- REQ-026: After a character written at COLS-1, cursor_pos SHALL become 16; after a character written at 16+COLS-1, cursor_pos SHALL become 0.
- REQ-027: When the wrap of REQ-026 occurs, the FSM SHALL issue the set-address command (0xC0 for line 2, 0x80 for line 1) itself via WRAP, using the same strobe/busy protocol as REQ-018..REQ-021, before returning to IDLE.
- REQ-028: The ready outputs SHALL stay 0 throughout an auto-inserted command.
- REQ-029: A WAIT_BUSY timeout SHALL cancel any pending wrap; cursor_pos SHALL keep its updated value.

Reset
- REQ-030: While reset is high, on the next clock edge: FSM=IDLE, lcd_d=0, lcd_data_ready=0, cursor_pos=0, and the pending wrap is cleared.
- REQ-031: cmd_ready and chr_ready SHALL be 0 in any cycle where reset is high.
- REQ-032: A reset asserted mid-transfer SHALL abandon the transfer; no further strobe SHALL be issued for it.

Configuration
- REQ-033: With LCD_SCHED_WRAP_EN defined, the line-wrap insertion of REQ-026..REQ-027 SHALL be compiled in.
- REQ-034: Without LCD_SCHED_WRAP_EN, the WRAP state SHALL be absent, no command SHALL be inserted, and cursor_pos SHALL increment modulo 32 on each character.

Structure
- REQ-035: lcd_pkg SHALL hold the state enum and the constants LCD_CMD_CLEAR=0x01, LCD_CMD_HOME=0x02, LCD_CMD_LINE1=0x80 and LCD_CMD_LINE2=0xC0.
- REQ-036: The sub-module lcd_cursor_tracker SHALL contain the cursor_pos register and the wrap-detect logic of REQ-022..REQ-026.

Verification
- REQ-037: With idle lcd_busy=0, cmd_valid and chr_valid both high (0x01 and 0x41) -> cmd accepted first, lcd_d=0x001 strobed one cycle, then lcd_d=0x141 after lcd_busy's rise/fall.
- REQ-038: Write 16 characters 'A' (COLS=16) with the macro defined -> the 16th char is followed by an autonomous lcd_d=0x0C0 strobe, chr_ready stays 0 until it completes, and cursor_pos=16.
- REQ-039: Same stimulus as REQ-038 without the macro -> no 0x0C0 strobe, and cursor_pos=16.
- REQ-040: Command 0xC5 -> cursor_pos=21; then command 0x02 -> cursor_pos=0.
- REQ-041: lcd_busy held at 0 after a strobe -> return to IDLE after exactly 4 cycles, then ready reasserts.
- REQ-042: reset pulsed during WAIT_DONE -> next cycle all outputs are 0, cursor_pos=0, and no strobe is issued afterwards.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared FSM state type and HD44780-style command constants for the LCD write scheduler.
// The WRAP state exists only when LCD_SCHED_WRAP_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
`ifdef LCD_SCHED_WRAP_EN
        ,
        WRAP
`endif
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;

endpackage

// File: rtl/lcd_cursor_tracker.sv
// Shadow copy of the display cursor, updated on every accepted byte.
// With LCD_SCHED_WRAP_EN it flags the end-of-line wrap; otherwise it counts modulo 32.
module lcd_cursor_tracker
    import lcd_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_acc,
    input  logic       i_rs,
    input  logic [7:0] i_data,
`ifdef LCD_SCHED_WRAP_EN
    output logic       o_wrap,
`endif
    output logic [4:0] o_cursor_pos
);

    logic [4:0] r_pos;
    logic [4:0] w_next;
    logic [6:0] w_addr;

    assign w_addr       = i_data[6:0];
    assign o_cursor_pos = r_pos;

`ifdef LCD_SCHED_WRAP_EN
    assign o_wrap = i_acc && i_rs && (r_pos == 5'(COLS - 1) || r_pos == 5'(16 + COLS - 1));
`endif

    always_comb begin
        w_next = r_pos;
        if (i_rs) begin
`ifdef LCD_SCHED_WRAP_EN
            if (r_pos == 5'(COLS - 1))
                w_next = 5'd16;
            else if (r_pos == 5'(16 + COLS - 1))
                w_next = 5'd0;
            else
                w_next = r_pos + 5'd1;
`else
            w_next = r_pos + 5'd1;
`endif
        end else if (i_data == LCD_CMD_CLEAR || i_data == LCD_CMD_HOME) begin
            w_next = 5'd0;
        end else if (i_data[7]) begin
            // DDRAM addresses outside the visible window leave the cursor alone
            if (w_addr < 7'(COLS))
                w_next = w_addr[4:0];
            else if (w_addr >= 7'h40 && w_addr < 7'(64 + COLS))
                w_next = 5'd16 + {1'b0, w_addr[3:0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_pos <= 5'd0;
        else if (i_acc)
            r_pos <= w_next;
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates command/character bytes onto the LCD write port with a strobe/busy handshake.
// Define LCD_SCHED_WRAP_EN to auto-insert the set-address command at end of line.
module lcd_write_scheduler
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       chr_valid,
    input  logic [7:0] chr_data,
    output logic       chr_ready,
    input  logic       lcd_busy,
    output logic [8:0] lcd_d,
    output logic       lcd_data_ready,
    output logic [4:0] cursor_pos
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    lcd_state_e       r_state;
    lcd_state_e       w_state_nxt;
    logic [8:0]       r_lcd_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_idle;
    logic             w_cmd_acc;
    logic             w_chr_acc;
    logic             w_acc;
    logic             w_timeout;
    logic [7:0]       w_byte;
    logic [4:0]       w_cursor;
`ifdef LCD_SCHED_WRAP_EN
    logic             w_wrap;
    logic             r_wrap_pend;
`endif

    // Commands outrank characters; nothing is accepted while reset is high
    assign w_idle    = (r_state == IDLE) && !reset;
    assign cmd_ready = w_idle && !lcd_busy;
    assign chr_ready = w_idle && !lcd_busy && !cmd_valid;
    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_chr_acc = chr_valid && chr_ready;
    assign w_acc     = w_cmd_acc || w_chr_acc;
    assign w_byte    = w_cmd_acc ? cmd_data : chr_data;
    assign w_timeout = (r_state == WAIT_BUSY) && !lcd_busy && (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    assign lcd_d          = r_lcd_d;
    assign lcd_data_ready = (r_state == ISSUE);
    assign cursor_pos     = w_cursor;

    lcd_cursor_tracker #(
        .COLS(COLS)
    ) u_cursor (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_acc       (w_acc),
        .i_rs        (w_chr_acc),
        .i_data      (w_byte),
`ifdef LCD_SCHED_WRAP_EN
        .o_wrap      (w_wrap),
`endif
        .o_cursor_pos(w_cursor)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_acc) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (lcd_busy)
                    w_state_nxt = WAIT_DONE;
                else if (w_timeout)
                    w_state_nxt = IDLE;
            end
            WAIT_DONE: begin
`ifdef LCD_SCHED_WRAP_EN
                if (!lcd_busy)
                    w_state_nxt = r_wrap_pend ? WRAP : IDLE;
`else
                if (!lcd_busy)
                    w_state_nxt = IDLE;
`endif
            end
`ifdef LCD_SCHED_WRAP_EN
            WRAP:      w_state_nxt = ISSUE;
`endif
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_lcd_d <= '0;
            r_cnt   <= '0;
`ifdef LCD_SCHED_WRAP_EN
            r_wrap_pend <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == WAIT_BUSY) ? r_cnt + 1'b1 : '0;
            if (w_acc)
                r_lcd_d <= {w_chr_acc, w_byte};
`ifdef LCD_SCHED_WRAP_EN
            // The tracker has already moved to the new line, so its top bit picks the address
            if (r_state == WRAP)
                r_lcd_d <= {1'b0, (w_cursor[4] ? LCD_CMD_LINE2 : LCD_CMD_LINE1)};
            if (w_acc)
                r_wrap_pend <= w_wrap;
            else if (w_timeout || r_state == WRAP)
                r_wrap_pend <= 1'b0;
`endif
        end
    end

endmodule
